// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b word/line types and the memory arbiter state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_8word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_ctr
// Description : Saturating count of dcache grants taken while icache waits;
//               flags starvation at STARVE_LIMIT. Used under ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam int              c_CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign starved = (r_count >= c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_ctrl
// Description : Arbitrates L1 icache/dcache line traffic onto a single L2 port,
//               dcache first; optional icache starvation guard via the
//               ARB_STARVE_GUARD_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_ctrl
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      icache_read,
    input  logic      dcache_read,
    input  logic      dcache_write,
    input  lc3b_word  icache_address,
    input  lc3b_word  dcache_address,
    input  lc3b_8word dcache_wdata,
    input  logic      pmem_resp,
    input  lc3b_8word pmem_rdata,
    output logic      icache_mem_resp,
    output logic      dcache_mem_resp,
    output lc3b_8word icache_rdata,
    output lc3b_8word dcache_rdata,
    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_8word pmem_wdata
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_dreq;
    logic       w_take_d;

    assign w_dreq = dcache_read | dcache_write;

`ifdef ARB_STARVE_GUARD_EN
    logic w_starved;
    logic w_idle;

    assign w_idle   = (r_state == IDLE);
    // A starved icache overrides dcache priority for one arbitration.
    assign w_take_d = w_dreq & ~(icache_read & w_starved);

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_idle & w_take_d & icache_read),
        .clr     (w_idle & (~icache_read | ~w_take_d)),
        .starved (w_starved)
    );
`else
    assign w_take_d = w_dreq;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_d) begin
                    w_next = GRANT_D;
                end else if (icache_read) begin
                    w_next = GRANT_I;
                end
            end
            GRANT_I: if (pmem_resp | ~icache_read) w_next = IDLE;
            GRANT_D: if (pmem_resp | ~w_dreq)      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = icache_address;
        icache_mem_resp = 1'b0;
        dcache_mem_resp = 1'b0;
        case (r_state)
            GRANT_I: begin
                pmem_read       = icache_read;
                icache_mem_resp = pmem_resp;
            end
            GRANT_D: begin
                pmem_address    = dcache_address;
                pmem_read       = dcache_read;
                pmem_write      = dcache_write & ~dcache_read;
                dcache_mem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;
    assign pmem_wdata   = dcache_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter_ctrl
// Description : Self-checking bench for mem_arbiter_ctrl against a
//               transaction-level ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_ctrl;
    import lc3b_types::*;

    localparam int STARVE_LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      icache_read = 1'b0, dcache_read = 1'b0, dcache_write = 1'b0;
    lc3b_word  icache_address = '0, dcache_address = '0;
    lc3b_8word dcache_wdata = '0, pmem_rdata = '0;
    logic      pmem_resp = 1'b0;
    logic      icache_mem_resp, dcache_mem_resp, pmem_read, pmem_write;
    lc3b_8word icache_rdata, dcache_rdata, pmem_wdata;
    lc3b_word  pmem_address;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: who owns the L2 port (0 none, 1 icache, 2 dcache) and the
    // number of dcache grants taken while icache was waiting.
    int m_owner  = 0;
    int m_starve = 0;

    logic [19:0] obs;
    assign obs = {icache_mem_resp, dcache_mem_resp, pmem_read, pmem_write, pmem_address};

    mem_arbiter_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .dcache_read(dcache_read), .dcache_write(dcache_write),
        .icache_address(icache_address), .dcache_address(dcache_address),
        .dcache_wdata(dcache_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .icache_mem_resp(icache_mem_resp), .dcache_mem_resp(dcache_mem_resp),
        .icache_rdata(icache_rdata), .dcache_rdata(dcache_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] model_exp();
        logic [19:0] e;
        e = {4'b0000, icache_address};
        if (m_owner == 1)
            e = {pmem_resp, 1'b0, icache_read, 1'b0, icache_address};
        else if (m_owner == 2)
            e = {1'b0, pmem_resp, dcache_read, dcache_write & ~dcache_read, dcache_address};
        return e;
    endfunction

    task automatic model_tick();
        bit d, fav_i;
        d = dcache_read | dcache_write;
        if (rst) begin
            m_owner  = 0;
            m_starve = 0;
        end else if (m_owner == 0) begin
            fav_i = GUARD && icache_read && (m_starve >= STARVE_LIMIT);
            if (d && !fav_i) begin
                m_owner = 2;
                if (icache_read && m_starve < STARVE_LIMIT) m_starve++;
            end else if (icache_read) begin
                m_owner  = 1;
                m_starve = 0;
            end
            if (!icache_read) m_starve = 0;
        end else if (pmem_resp || (m_owner == 1 ? !icache_read : !d)) begin
            m_owner = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        pmem_resp = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        icache_address = 16'($urandom); dcache_address = 16'($urandom);
        rst = 1'b1; icache_read = 1'b1; dcache_write = 1'b1; pmem_resp = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        n_cmp++;
        if (obs !== {4'b0000, icache_address}) begin
            n_fail++;
            $display("FAIL reset_idle got=%h want=%h", obs, {4'b0000, icache_address});
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_icache_fill();
        logic [19:0] e;
        icache_address = 16'h1230;
        for (int k = 0; k < 6; k++) begin
            icache_read = (k <= 4);
            pmem_resp   = (k == 4);
            e = {(k == 4), 1'b0, (k >= 1 && k <= 4), 1'b0, 16'h1230};
            @(negedge clk);
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL icache_fill k=%0d got=%h want=%h", k, obs, e);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        logic [19:0] e [7];
        e[0] = {4'b0000, 16'h1230}; e[1] = {4'b0001, 16'hBEE0}; e[2] = {4'b0101, 16'hBEE0};
        e[3] = {4'b0000, 16'h1230}; e[4] = {4'b0010, 16'h1230}; e[5] = {4'b1010, 16'h1230};
        e[6] = {4'b0000, 16'h1230};
        icache_address = 16'h1230; dcache_address = 16'hBEE0;
        for (int k = 0; k < 7; k++) begin
            icache_read  = (k <= 5);
            dcache_write = (k <= 2);
            pmem_resp    = (k == 2 || k == 5);
            dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
            pmem_rdata   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n_cmp++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL priority k=%0d got=%h want=%h", k, obs, e[k]);
            end
            n_cmp++;
            if (pmem_wdata !== dcache_wdata || icache_rdata !== pmem_rdata || dcache_rdata !== pmem_rdata) begin
                n_fail++;
                $display("FAIL data_path k=%0d wdata=%h irdata=%h drdata=%h", k, pmem_wdata, icache_rdata, dcache_rdata);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_nonowner_mid_grant();
        logic [19:0] e [8];
        e[0] = {4'b0000, 16'h4440}; e[1] = {4'b0010, 16'h4440}; e[2] = {4'b0010, 16'h4440};
        e[3] = {4'b1010, 16'h4440}; e[4] = {4'b0000, 16'h4440}; e[5] = {4'b0010, 16'h7770};
        e[6] = {4'b0110, 16'h7770}; e[7] = {4'b0000, 16'h4440};
        icache_address = 16'h4440; dcache_address = 16'h7770;
        for (int k = 0; k < 8; k++) begin
            icache_read = (k <= 3);
            dcache_read = (k >= 1 && k <= 6);
            pmem_resp   = (k == 3 || k == 6);
            @(negedge clk);
            n_cmp++;
            if (obs !== e[k]) begin
                n_fail++;
                $display("FAIL nonowner k=%0d got=%h want=%h", k, obs, e[k]);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_grant();
        logic [19:0] e;
        icache_address = 16'h0A00; dcache_address = 16'h0D00;
        for (int k = 0; k < 5; k++) begin
            dcache_read = (k <= 2);
            rst         = (k == 2);
            e = (k == 1 || k == 2) ? {4'b0010, 16'h0D00} : {4'b0000, 16'h0A00};
            @(negedge clk);
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d got=%h want=%h", k, obs, e);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_idle_resp();
        logic [19:0] e;
        icache_address = 16'h5550;
        for (int k = 0; k < 5; k++) begin
            pmem_resp   = (k <= 2);
            icache_read = (k >= 3);
            e = (k == 4) ? {4'b0010, 16'h5550} : {4'b0000, 16'h5550};
            @(negedge clk);
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL idle_resp k=%0d got=%h want=%h", k, obs, e);
            end
            cyc();
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_starve();
        int grants, first_i, want_i;
        grants = 0; first_i = 0;
        want_i = GUARD ? STARVE_LIMIT + 1 : 0;
        icache_address = 16'h1110; dcache_address = 16'h2220;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            icache_read = 1'b1;
            dcache_read = 1'b1;
            pmem_resp   = (m_owner != 0);
            @(negedge clk);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_fail++;
                $display("FAIL starve_cycle k=%0d got=%h want=%h", k, obs, model_exp());
            end
            if (pmem_read || pmem_write) begin
                grants++;
                if (icache_mem_resp && first_i == 0) first_i = grants;
            end
            cyc();
        end
        n_cmp++;
        if (first_i != want_i) begin
            n_fail++;
            $display("FAIL starve_first_icache_grant got=%0d want=%0d", first_i, want_i);
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) icache_read  = ~icache_read;
            if ($urandom_range(0, 6) == 0) dcache_read  = ~dcache_read;
            if ($urandom_range(0, 6) == 0) dcache_write = ~dcache_write;
            pmem_resp = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) icache_address = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dcache_address = 16'($urandom);
            @(negedge clk);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_fail++;
                $display("FAIL random k=%0d owner=%0d got=%h want=%h", k, m_owner, obs, model_exp());
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_icache_fill();
        test_priority();
        test_nonowner_mid_grant();
        test_reset_mid_grant();
        test_idle_resp();
        test_starve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_ctrl.md
MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive dcache grants allowed while icache waits (guard feature only).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 icache_read  input  1  L1 instruction cache line-fill request, held until icache_mem_resp.
REQ-005 dcache_read, dcache_write  input  1 each  L1 data cache fill/writeback request, held until dcache_mem_resp.
REQ-006 icache_address, dcache_address  input  lc3b_word  line addresses.
REQ-007 dcache_wdata  input  lc3b_8word  writeback line.
REQ-008 pmem_resp  input  1  L2 completion pulse; pmem_rdata  input  lc3b_8word  fill line.
REQ-009 icache_mem_resp, dcache_mem_resp  output  1 each  completion to owning L1.
REQ-010 icache_rdata, dcache_rdata  output  lc3b_8word  both driven from pmem_rdata.
REQ-011 pmem_read, pmem_write  output  1 each  request to L2; pmem_address  output  lc3b_word; pmem_wdata  output  lc3b_8word  = dcache_wdata.

Function
REQ-012 FSM states SHALL be IDLE, GRANT_I, GRANT_D; the owner is latched for the full transaction.
REQ-013 IDLE: all pmem_* strobes and both mem_resp outputs 0; pmem_address = icache_address.
REQ-014 IDLE arbitration, sampled at the clock edge: any dcache request -> GRANT_D; else icache_read -> GRANT_I; else stay.
REQ-015 Grant latency: exactly one cycle from request assertion in IDLE to strobe assertion.
REQ-016 GRANT_D: pmem_address = dcache_address; pmem_read = dcache_read; pmem_write = dcache_write & ~dcache_read (read wins if both high).
REQ-017 GRANT_I: pmem_address = icache_address; pmem_read = icache_read; pmem_write = 0.
REQ-018 mem_resp SHALL be pmem_resp gated combinationally to the current owner only; the non-owner resp is 0.
REQ-019 pmem_resp in a grant state -> IDLE next cycle; back-to-back transactions have exactly one IDLE bubble.
REQ-020 Owner dropping its request before pmem_resp (abort) -> strobes drop the same cycle, IDLE next cycle.
REQ-021 A non-owner request arriving mid-grant SHALL NOT disturb the owner; it is arbitrated in the following IDLE.
REQ-022 pmem_resp while in IDLE SHALL be ignored: no resp forwarded, no state change.

Reset
REQ-023 rst high at a clock edge -> IDLE, starvation counter 0; all outputs reach their IDLE values that cycle, including mid-transaction.
REQ-024 rst has priority over pmem_resp and all requests at the same edge.

Configuration
REQ-025 Macro ARB_STARVE_GUARD_EN, defined: a saturating counter increments on each GRANT_D entry made while icache_read is high; on reaching STARVE_LIMIT, the next IDLE arbitration with icache_read high grants icache.
REQ-026 With the guard, the counter clears on GRANT_I entry or on any IDLE cycle with icache_read low.
REQ-027 Macro undefined: strict dcache priority; no counter logic.

Structure
REQ-028 The state enum (arb_state_t) SHALL be added to lc3b_types; lc3b_word and lc3b_8word come from lc3b_types.
REQ-029 One sub-module: arb_starve_ctr (counter plus threshold compare), instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-030 icache_read=1, address 0x1230, pmem_resp 3 cycles after strobe -> pmem_read at cycle 1, pmem_address 0x1230, one icache_mem_resp pulse, IDLE after.
REQ-031 icache_read and dcache_write both raised in the same cycle -> dcache granted (pmem_write, dcache_address); icache granted after resp plus one bubble.
REQ-032 dcache_read raised during GRANT_I -> pmem_address stays icache_address until icache resp; dcache_mem_resp stays 0 throughout.
REQ-033 rst asserted 2 cycles into a GRANT_D with pmem_resp not yet seen -> next cycle pmem_read=0, pmem_write=0, state IDLE.
REQ-034 Guard on, STARVE_LIMIT=4, dcache re-requests continuously, icache_read held -> icache granted in the fifth arbitration.
REQ-035 Guard off, same stimulus as REQ-034 -> icache never granted while dcache requests; pmem_resp pulsed in IDLE -> no resp outputs.
